// File: rtl/disp_arbiter.sv
// Two-requester round-robin arbiter for a shared seven-segment display.
// The owner holds the display for HOLD_CYCLES clocks; its code is latched on grant.
module disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned NBITS_SEG   = 8
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic                 req_a,
    input  logic [1:0]           dat_a,
    input  logic                 req_b,
    input  logic [1:0]           dat_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic [1:0]           disp_val,
    output logic [NBITS_SEG-1:0] SEG,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    state_t     pick;
    logic [7:0] cnt, cnt_nxt;
    logic       last_b, last_b_nxt;
    logic [1:0] disp_nxt;
    logic       reselect;
    logic [7:0] pat;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_b   <= 1'b1;
            disp_val <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_b   <= last_b_nxt;
            disp_val <= disp_nxt;
        end
    end

    // Tie goes to whoever was not granted last.
    always_comb begin
        pick = IDLE;
        if (req_a && req_b)
            pick = last_b ? OWN_A : OWN_B;
        else if (req_a)
            pick = OWN_A;
        else if (req_b)
            pick = OWN_B;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_b_nxt = last_b;
        disp_nxt   = disp_val;
        reselect   = 1'b0;

        case (state)
            IDLE: reselect = 1'b1;
            OWN_A: begin
                if (!req_a || cnt == '0)
                    reselect = 1'b1;
                else
                    cnt_nxt = cnt - 8'd1;
            end
            OWN_B: begin
                if (!req_b || cnt == '0)
                    reselect = 1'b1;
                else
                    cnt_nxt = cnt - 8'd1;
            end
            default: reselect = 1'b1;
        endcase

        // Re-granting the current owner also lands here, so it starts a fresh slot.
        if (reselect) begin
            state_nxt = pick;
            case (pick)
                OWN_A: begin
                    cnt_nxt    = HOLD_LOAD;
                    disp_nxt   = dat_a;
                    last_b_nxt = 1'b0;
                end
                OWN_B: begin
                    cnt_nxt    = HOLD_LOAD;
                    disp_nxt   = dat_b;
                    last_b_nxt = 1'b1;
                end
                default: begin
                    cnt_nxt  = '0;
                    disp_nxt = '0;
                end
            endcase
        end
    end

    assign gnt_a = (state == OWN_A);
    assign gnt_b = (state == OWN_B);
    assign busy  = gnt_a | gnt_b;

    always_comb begin
        case (disp_val)
            2'b01:   pat = 8'b0011_1111;
            2'b10:   pat = 8'b0000_0110;
            2'b11:   pat = 8'b0101_1011;
            default: pat = 8'b0000_0000;
        endcase
    end

    for (genvar g = 0; g < NBITS_SEG; g++) begin : g_seg
        if (g < 8) begin : g_bit
            assign SEG[g] = pat[g];
        end else begin : g_pad
            assign SEG[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed table-driven bench for disp_arbiter, plus hand sequences for
// asynchronous reset mid-slot and single-cycle slots.
module tb_disp_arbiter;

    localparam logic [7:0] S_BL = 8'h00;
    localparam logic [7:0] S_0  = 8'h3F;
    localparam logic [7:0] S_1  = 8'h06;
    localparam logic [7:0] S_2  = 8'h5B;
    localparam logic [12:0] RST_OUT = 13'b0;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b1;
    logic       rst1_n = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] dat_a = 2'b00, dat_b = 2'b00;

    logic       gnt_a4, gnt_b4, busy4;
    logic [1:0] disp4;
    logic [7:0] seg4;
    logic       gnt_a1, gnt_b1, busy1;
    logic [1:0] disp1;
    logic [7:0] seg1;

    logic [12:0] o4, o1;
    assign o4 = {gnt_a4, gnt_b4, disp4, seg4, busy4};
    assign o1 = {gnt_a1, gnt_b1, disp1, seg1, busy1};

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk_2 = ~clk_2;

    disp_arbiter #(.HOLD_CYCLES(4), .NBITS_SEG(8)) dut4 (
        .clk_2(clk_2), .reset_n(reset_n),
        .req_a(req_a), .dat_a(dat_a), .req_b(req_b), .dat_b(dat_b),
        .gnt_a(gnt_a4), .gnt_b(gnt_b4), .disp_val(disp4), .SEG(seg4), .busy(busy4)
    );

    disp_arbiter #(.HOLD_CYCLES(1), .NBITS_SEG(8)) dut1 (
        .clk_2(clk_2), .reset_n(rst1_n),
        .req_a(req_a), .dat_a(dat_a), .req_b(req_b), .dat_b(dat_b),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .disp_val(disp1), .SEG(seg1), .busy(busy1)
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic        ra;
        logic [1:0]  da;
        logic        rb;
        logic [1:0]  db;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic rst,
                                input logic ra, input logic [1:0] da,
                                input logic rb, input logic [1:0] db,
                                input logic ga, input logic gb,
                                input logic [1:0] dv, input logic [7:0] sg,
                                input logic bz);
        vec_t v;
        v.nm  = nm;
        v.rst = rst;
        v.ra  = ra;
        v.da  = da;
        v.rb  = rb;
        v.db  = db;
        v.exp = {ga, gb, dv, sg, bz};
        return v;
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got {ga,gb,disp,seg,busy}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     nm, act[12], act[11], act[10:9], act[8:1], act[0],
                     exp[12], exp[11], exp[10:9], exp[8:1], exp[0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 name          rst ra da     rb db      ga gb disp   seg  busy
        tbl.push_back(mk("rst_held",     0, 0, 2'b00, 0, 2'b00,  0, 0, 2'b00, S_BL, 0));
        tbl.push_back(mk("idle",         1, 0, 2'b00, 0, 2'b00,  0, 0, 2'b00, S_BL, 0));
        tbl.push_back(mk("tie_a1",       1, 1, 2'b01, 1, 2'b11,  1, 0, 2'b01, S_0,  1));
        tbl.push_back(mk("tie_a2",       1, 1, 2'b01, 1, 2'b11,  1, 0, 2'b01, S_0,  1));
        tbl.push_back(mk("tie_a3",       1, 1, 2'b01, 1, 2'b11,  1, 0, 2'b01, S_0,  1));
        tbl.push_back(mk("tie_a4",       1, 1, 2'b01, 1, 2'b11,  1, 0, 2'b01, S_0,  1));
        tbl.push_back(mk("tie_b1",       1, 1, 2'b01, 1, 2'b11,  0, 1, 2'b11, S_2,  1));
        tbl.push_back(mk("tie_b2",       1, 1, 2'b01, 1, 2'b11,  0, 1, 2'b11, S_2,  1));
        tbl.push_back(mk("tie_b3",       1, 1, 2'b01, 1, 2'b11,  0, 1, 2'b11, S_2,  1));
        tbl.push_back(mk("tie_b4",       1, 1, 2'b01, 1, 2'b11,  0, 1, 2'b11, S_2,  1));
        tbl.push_back(mk("tie_a_again",  1, 1, 2'b01, 1, 2'b11,  1, 0, 2'b01, S_0,  1));
        tbl.push_back(mk("both_drop",    1, 0, 2'b01, 0, 2'b11,  0, 0, 2'b00, S_BL, 0));
        tbl.push_back(mk("b_only",       1, 0, 2'b00, 1, 2'b10,  0, 1, 2'b10, S_1,  1));
        tbl.push_back(mk("b_dat_chg2",   1, 0, 2'b00, 1, 2'b01,  0, 1, 2'b10, S_1,  1));
        tbl.push_back(mk("b_dat_chg3",   1, 0, 2'b00, 1, 2'b01,  0, 1, 2'b10, S_1,  1));
        tbl.push_back(mk("b_dat_chg4",   1, 0, 2'b00, 1, 2'b01,  0, 1, 2'b10, S_1,  1));
        tbl.push_back(mk("b_regrant",    1, 0, 2'b00, 1, 2'b01,  0, 1, 2'b01, S_0,  1));
        tbl.push_back(mk("b_drop",       1, 0, 2'b00, 0, 2'b01,  0, 0, 2'b00, S_BL, 0));
        tbl.push_back(mk("a_only",       1, 1, 2'b10, 0, 2'b00,  1, 0, 2'b10, S_1,  1));
        tbl.push_back(mk("a_drop_c2",    1, 0, 2'b10, 0, 2'b00,  0, 0, 2'b00, S_BL, 0));
        tbl.push_back(mk("a_only2",      1, 1, 2'b11, 0, 2'b00,  1, 0, 2'b11, S_2,  1));
        tbl.push_back(mk("a_early_to_b", 1, 0, 2'b11, 1, 2'b10,  0, 1, 2'b10, S_1,  1));
        tbl.push_back(mk("b_hold",       1, 0, 2'b11, 1, 2'b10,  0, 1, 2'b10, S_1,  1));

        // Assert both resets asynchronously before any clock edge.
        #1;
        reset_n = 1'b0;
        rst1_n  = 1'b0;
        #1;
        check("reset_state", o4, RST_OUT);
        check("reset_state_h1", o1, RST_OUT);

        @(posedge clk_2);
        #1;
        foreach (tbl[i]) begin
            reset_n = tbl[i].rst;
            req_a   = tbl[i].ra;
            dat_a   = tbl[i].da;
            req_b   = tbl[i].rb;
            dat_b   = tbl[i].db;
            @(posedge clk_2);
            #1;
            check(tbl[i].nm, o4, tbl[i].exp);
        end

        // Still owning B: pulse reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_in_b", o4, RST_OUT);
        #1;
        reset_n = 1'b1;
        req_a = 1'b1; dat_a = 2'b01;
        req_b = 1'b1; dat_b = 2'b11;
        @(posedge clk_2);
        #1;
        check("post_rst_tie_a", o4, {1'b1, 1'b0, 2'b01, S_0, 1'b1});

        // Now A was granted last; reset must restore the A-wins tie rule.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_in_a", o4, RST_OUT);
        #1;
        reset_n = 1'b1;
        @(posedge clk_2);
        #1;
        check("post_rst2_tie_a", o4, {1'b1, 1'b0, 2'b01, S_0, 1'b1});

        // Single-cycle slots: strict alternation starting with A.
        check("h1_still_reset", o1, RST_OUT);
        rst1_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_2);
            #1;
            if (i % 2 == 0)
                check($sformatf("h1_alt%0d_a", i), o1, {1'b1, 1'b0, 2'b01, S_0, 1'b1});
            else
                check($sformatf("h1_alt%0d_b", i), o1, {1'b0, 1'b1, 2'b11, S_2, 1'b1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 4, the slot length in clk_2 cycles that a granted requester owns the display (legal range 1..255).
REQ-002 The module SHALL have parameter NBITS_SEG, default 8, the width of the seven-segment output.
REQ-003 The module SHALL have port clk_2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req_a, input, 1 bit: requester A level request.
REQ-006 The module SHALL have port dat_a, input, 2 bits: requester A display code.
REQ-007 The module SHALL have port req_b, input, 1 bit: requester B level request.
REQ-008 The module SHALL have port dat_b, input, 2 bits: requester B display code.
REQ-009 The module SHALL have port gnt_a, output, 1 bit: A owns the display.
REQ-010 The module SHALL have port gnt_b, output, 1 bit: B owns the display.
REQ-011 The module SHALL have port disp_val, output, 2 bits: code captured from the current owner.
REQ-012 The module SHALL have port SEG, output, NBITS_SEG bits: decoded segment pattern of disp_val.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever either grant is high.

Function
REQ-014 FSM states SHALL be IDLE, OWN_A and OWN_B; gnt_a = (state==OWN_A), gnt_b = (state==OWN_B), both registered, never high together.
REQ-015 A round-robin flag last_b SHALL record the most recently granted requester (1 = B).
REQ-016 In IDLE, with only req_a high, the next edge SHALL enter OWN_A; with only req_b high, OWN_B; both high -> the requester not equal to last; neither -> stay in IDLE.
REQ-017 Grant latency SHALL be exactly one cycle: a request sampled high at edge N in IDLE yields the grant after edge N.
REQ-018 On entering OWN_x, dat_x SHALL be captured into disp_val and slot counter loaded with HOLD_CYCLES-1; later changes to dat_x during the slot SHALL be ignored.
REQ-019 In OWN_x, the counter SHALL decrement each cycle; the grant lasts exactly HOLD_CYCLES cycles unless req_x drops.
REQ-020 When the counter reaches 0, the next edge SHALL select as in REQ-016, with the other requester taking priority; handover from A to B (or B to A) SHALL be direct with no idle cycle; re-granting the same requester SHALL start a new slot and recapture data.
REQ-021 If req_x is sampled low while in OWN_x, the next edge SHALL leave the slot early and apply the REQ-016 selection.
REQ-022 SEG SHALL decode disp_val: 00 -> 8'b00000000 (blank), 01 -> 8'b00111111 ('0'), 10 -> 8'b00000110 ('1'), 11 -> 8'b01011011 ('2').
REQ-023 In IDLE, disp_val SHALL be 00 and SEG SHALL be blank.
REQ-024 HOLD_CYCLES=1 SHALL give one-cycle slots with alternation every cycle under continuous dual requests.

Reset
REQ-025 reset_n low SHALL immediately, without waiting for a clock edge, force state IDLE, gnt_a=0, gnt_b=0, busy=0, disp_val=00, SEG=8'h00, counter=0, last_b=1.
REQ-026 Reset asserted mid-slot SHALL abort the slot; after release, the first grant SHALL follow REQ-016 with last_b=1, so A wins a tie.

Verification
REQ-027 Reset release, then req_a=req_b=1 held, dat_a=01, dat_b=11, HOLD_CYCLES=4 -> gnt_a for 4 cycles with SEG=00111111, then gnt_b for 4 cycles with SEG=01011011, alternating with no gap.
REQ-028 Only req_b=1, dat_b=10 -> gnt_b one cycle after the request edge, SEG=00000110; dat_b changed to 01 mid-slot -> SEG unchanged until the next slot.
REQ-029 req_a dropped in cycle 2 of its slot with req_b=0 -> back in IDLE next edge, gnt_a=0, SEG=00000000, busy=0.
REQ-030 reset_n pulsed low asynchronously during OWN_B -> outputs at reset values before the next clk_2 edge; with both requests high after release -> A granted first.
REQ-031 HOLD_CYCLES=1, both requests held -> gnt_a and gnt_b toggle every cycle, never both high, busy constantly 1.
